// File: rtl/adder_pipe_if.sv
// Handshake and result bundle for adder_pipe: operand side plus result side.
interface adder_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out, cout, ovf, zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out, cout, ovf, zero
    );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract: STAGES registered carry-chain segments of
// WIDTH/STAGES bits each, with a global stall driven by result back-pressure.
module adder_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input logic         clk,
    input logic         rst,
    adder_pipe_if.slave bus
);
    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    logic stall;
    logic last_valid;
    logic msb_carry;
    logic ovf_q;
    logic zero_q;

    assign stall        = last_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // Stage k holds the finished low bits and only the operand bits above them.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * CHUNK;
        localparam int unsigned HI = LO + CHUNK;

        logic [WIDTH-LO-1:0] a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic                v_in;
        logic                c_in;
        logic [CHUNK:0]      sum;
        logic [HI-1:0]       res_d;
        logic                v_q;
        logic                c_q;
        logic [HI-1:0]       res_q;

        if (k == 0) begin : g_head
            assign v_in  = bus.in_valid;
            assign c_in  = bus.in_cin;
            assign a_in  = bus.in_a;
            assign b_in  = bus.in_sub ? ~bus.in_b : bus.in_b;
            assign res_d = sum[CHUNK-1:0];
        end else begin : g_body
            assign v_in  = g_stage[k-1].v_q;
            assign c_in  = g_stage[k-1].c_q;
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign b_in  = g_stage[k-1].g_fwd.b_q;
            assign res_d = {sum[CHUNK-1:0], g_stage[k-1].res_q};
        end

        assign sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, c_in};

        // Data only loads behind a valid entry so outputs hold across bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (!stall) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q   <= sum[CHUNK];
                    res_q <= res_d;
                end
            end
        end

        if (k < LAST) begin : g_fwd
            logic [WIDTH-HI-1:0] a_q;
            logic [WIDTH-HI-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall && v_in) begin
                    a_q <= a_in[WIDTH-LO-1:CHUNK];
                    b_q <= b_in[WIDTH-LO-1:CHUNK];
                end
            end
        end
    end

    assign last_valid = g_stage[LAST].v_q;

    // Carry into the MSB recovered from the MSB's own sum bit and operands.
    assign msb_carry = g_stage[LAST].a_in[CHUNK-1] ^ g_stage[LAST].b_in[CHUNK-1]
                     ^ g_stage[LAST].sum[CHUNK-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall && g_stage[LAST].v_in) begin
            ovf_q  <= msb_carry ^ g_stage[LAST].sum[CHUNK];
            zero_q <= ~|g_stage[LAST].res_d;
        end
    end

    assign bus.out_valid = last_valid;
    assign bus.out       = g_stage[LAST].res_q;
    assign bus.cout      = g_stage[LAST].c_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed cases, back-pressure scoreboard, mid-flight
// reset and a multi-configuration random sweep against an arithmetic model.
module tb_adder_pipe;
    localparam int SW_N = 2500;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    adder_pipe_if #(.WIDTH(16)) m  ();
    adder_pipe_if #(.WIDTH(32)) s1 ();
    adder_pipe_if #(.WIDTH(32)) s2 ();
    adder_pipe_if #(.WIDTH(32)) s3 ();
    adder_pipe_if #(.WIDTH(8))  s4 ();

    adder_pipe #(.WIDTH(16), .STAGES(4))  dut    (.clk(clk), .rst(rst), .bus(m));
    adder_pipe #(.WIDTH(32), .STAGES(1))  dut_s1 (.clk(clk), .rst(rst), .bus(s1));
    adder_pipe #(.WIDTH(32), .STAGES(4))  dut_s2 (.clk(clk), .rst(rst), .bus(s2));
    adder_pipe #(.WIDTH(32), .STAGES(32)) dut_s3 (.clk(clk), .rst(rst), .bus(s3));
    adder_pipe #(.WIDTH(8),  .STAGES(2))  dut_s4 (.clk(clk), .rst(rst), .bus(s4));

    logic        hv [SW_N+40];
    logic [31:0] ha [SW_N+40];
    logic [31:0] hb [SW_N+40];
    logic        hs [SW_N+40];
    logic        hc [SW_N+40];
    logic [34:0] exp_q [$];

    // Returns {zero, ovf, cout, out} for a w-bit add of A and (sub ? ~B : B) plus cin.
    function automatic logic [34:0] model(input int unsigned w, input logic [31:0] a,
                                          input logic [31:0] b, input logic sub, input logic cin);
        logic [63:0] mask, am, bm, s;
        logic [31:0] o;
        logic        c, ov, z;
        mask = (64'd1 << w) - 64'd1;
        am   = {32'd0, a} & mask;
        bm   = {32'd0, (sub ? ~b : b)} & mask;
        s    = am + bm + {63'd0, cin};
        o    = s[31:0] & mask[31:0];
        c    = s[w];
        ov   = (am[w-1] == bm[w-1]) && (o[w-1] != am[w-1]);
        z    = (o == 32'd0);
        return {z, ov, c, o};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic cin, input logic [15:0] eo,
                            input logic ec, input logic ev, input logic ez);
        m.in_a = a; m.in_b = b; m.in_sub = sub; m.in_cin = cin;
        m.in_valid = 1'b1; m.out_ready = 1'b1;
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        repeat (3) begin
            check({tag, " early valid"}, m.out_valid, 1'b0);
            @(posedge clk); #1;
        end
        check({tag, " valid"}, m.out_valid, 1'b1);
        check({tag, " out"},   m.out,  eo);
        check({tag, " cout"},  m.cout, ec);
        check({tag, " ovf"},   m.ovf,  ev);
        check({tag, " zero"},  m.zero, ez);
        @(posedge clk); #1;
    endtask

    task automatic sweep_check(input string tag, input int unsigned w, input int stg, input int j,
                               input logic v, input logic [34:0] obs);
        int   idx;
        logic expv;
        idx  = j - stg + 1;
        expv = (idx >= 0) ? hv[idx] : 1'b0;
        check({tag, " valid"}, v, expv);
        if (expv)
            check({tag, " result"}, obs, model(w, ha[idx], hb[idx], hs[idx], hc[idx]));
    endtask

    initial begin
        int issued, got;
        logic offering;

        rst = 1'b1;
        {m.in_valid, m.in_a, m.in_b, m.in_sub, m.in_cin} = '0;
        m.out_ready = 1'b1;
        {s1.in_valid, s1.in_a, s1.in_b, s1.in_sub, s1.in_cin} = '0;
        {s2.in_valid, s2.in_a, s2.in_b, s2.in_sub, s2.in_cin} = '0;
        {s3.in_valid, s3.in_a, s3.in_b, s3.in_sub, s3.in_cin} = '0;
        {s4.in_valid, s4.in_a, s4.in_b, s4.in_sub, s4.in_cin} = '0;
        s1.out_ready = 1'b1; s2.out_ready = 1'b1; s3.out_ready = 1'b1; s4.out_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        check("in_ready in reset", m.in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("reset out_valid", m.out_valid, 1'b0);
        check("reset out",       m.out, 16'h0);
        check("reset flags",     {m.cout, m.ovf, m.zero}, 3'b000);
        check("in_ready after reset", m.in_ready, 1'b1);
        @(posedge clk); #1;

        directed("add",      16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        directed("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("pos ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("sub neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        directed("sub ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Back-pressure with a scoreboard
        issued = 0; got = 0; offering = 1'b0;
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            if (!offering && issued < 10 && $urandom_range(0, 3) != 0) begin
                offering  = 1'b1;
                m.in_a    = 16'($urandom);
                m.in_b    = 16'($urandom);
                m.in_sub  = 1'($urandom_range(0, 1));
                m.in_cin  = 1'($urandom_range(0, 1));
            end
            m.in_valid  = offering;
            m.out_ready = 1'($urandom_range(0, 1));
            #1;
            check("bp in_ready rule", m.in_ready, !(m.out_valid && !m.out_ready));
            if (m.out_valid) begin
                check("bp result pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    check("bp result", {m.zero, m.ovf, m.cout, 16'h0, m.out}, exp_q[0]);
                    if (m.out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (offering && m.in_ready) begin
                exp_q.push_back(model(16, {16'h0, m.in_a}, {16'h0, m.in_b}, m.in_sub, m.in_cin));
                issued++;
                offering = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("bp received", got, 10);
        check("bp leftover", exp_q.size(), 0);
        m.in_valid = 1'b0; m.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("bp no extra", m.out_valid, 1'b0);

        // Reset mid-flight
        m.in_a = 16'h1234; m.in_b = 16'h1111; m.in_sub = 1'b0; m.in_cin = 1'b0;
        m.in_valid = 1'b1;
        @(posedge clk); #1;
        m.in_a = 16'h4321;
        @(posedge clk); #1;
        m.in_a = 16'h0F0F;
        rst = 1'b1;
        #1;
        check("in_ready mid reset", m.in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0; m.in_valid = 1'b0;
        check("mid reset out", m.out, 16'h0);
        check("mid reset flags", {m.cout, m.ovf, m.zero}, 3'b000);
        for (int i = 0; i < 6; i++) begin
            check("post reset quiet", m.out_valid, 1'b0);
            @(posedge clk); #1;
        end
        directed("after reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

        // Parameter sweep with random bubbles
        for (int j = 0; j < SW_N + 34; j++) begin
            hv[j] = (j < SW_N) && ($urandom_range(0, 7) != 0);
            ha[j] = $urandom; hb[j] = $urandom;
            if (j % 16 == 0) ha[j] = '1;
            if (j % 32 == 5) hb[j] = 32'h1;
            hs[j] = 1'($urandom_range(0, 1));
            hc[j] = 1'($urandom_range(0, 1));
            {s1.in_valid, s1.in_a, s1.in_b, s1.in_sub, s1.in_cin} = {hv[j], ha[j], hb[j], hs[j], hc[j]};
            {s2.in_valid, s2.in_a, s2.in_b, s2.in_sub, s2.in_cin} = {hv[j], ha[j], hb[j], hs[j], hc[j]};
            {s3.in_valid, s3.in_a, s3.in_b, s3.in_sub, s3.in_cin} = {hv[j], ha[j], hb[j], hs[j], hc[j]};
            {s4.in_valid, s4.in_a, s4.in_b, s4.in_sub, s4.in_cin} =
                {hv[j], ha[j][7:0], hb[j][7:0], hs[j], hc[j]};
            @(posedge clk); #1;
            sweep_check("w32s1",  32, 1,  j, s1.out_valid, {s1.zero, s1.ovf, s1.cout, s1.out});
            sweep_check("w32s4",  32, 4,  j, s2.out_valid, {s2.zero, s2.ovf, s2.cout, s2.out});
            sweep_check("w32s32", 32, 32, j, s3.out_valid, {s3.zero, s3.ovf, s3.cout, s3.out});
            sweep_check("w8s2",   8,  2,  j, s4.out_valid, {s4.zero, s4.ovf, s4.cout, 24'h0, s4.out});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
